// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares the single register-file write port between the ALU
//             result path and the memory-load return path. The module uses
//             valid/ready handshakes and round-robin fairness. Write enables
//             and write data are registered and one-hot. A 4-entry
//             pending-load scoreboard drives the decode hazard and blocks
//             write-after-write reordering of an ALU write behind a load.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock, asynchronous active-high reset
//    alu_valid/rd/data/kill   ALU writeback request; kill drops the write
//    alu_ready                ALU request accepted this cycle (comb)
//    mem_valid/rd/data        load-return writeback request
//    mem_ready                load request accepted this cycle (comb)
//    mem_issue, mem_issue_rd  load issued this cycle and its destination
//    rs_a, rs_b               decode source operands
//    hazard                   a decode source has a load pending (comb)
//    wb_data, wb_rd           registered write data / index
//    reg0_en..reg3_en         registered one-hot write enables
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [1:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_kill,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [1:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              mem_issue,
    input  logic [1:0]        mem_issue_rd,
    input  logic [1:0]        rs_a,
    input  logic [1:0]        rs_b,
    output logic              hazard,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_rd,
    output logic              reg0_en,
    output logic              reg1_en,
    output logic              reg2_en,
    output logic              reg3_en
);

    // Identity of the most recently granted live writer.
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              last_grant_q, last_grant_d;
    logic [3:0]        pend_q,       pend_d;
    logic [3:0]        wb_en_q,      wb_en_d;
    logic [DATA_W-1:0] wb_data_q,    wb_data_d;
    logic [1:0]        wb_rd_q,      wb_rd_d;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic w_alu_killed;
    logic w_alu_elig;
    logic w_mem_elig;
    logic w_grant_alu;
    logic w_grant_mem;

    // A killed request is a handshake with no write. It never competes
    // for the port.
    assign w_alu_killed = alu_valid & alu_kill;

    // An ALU write to a register with a load outstanding would be
    // overwritten later by that load. Hold it until the load returns.
    assign w_alu_elig   = alu_valid & ~alu_kill & ~pend_q[alu_rd];
    assign w_mem_elig   = mem_valid;

    // Round robin: under contention the requester that did not win last
    // time gets the port.
    assign w_grant_alu  = w_alu_elig & (~w_mem_elig | (last_grant_q == GRANT_MEM));
    assign w_grant_mem  = w_mem_elig & (~w_alu_elig | (last_grant_q == GRANT_ALU));

    assign alu_ready    = w_alu_killed | w_grant_alu;
    assign mem_ready    = w_grant_mem;

    // Registered scoreboard only: a load issued this cycle shows up in
    // the hazard on the next cycle.
    assign hazard       = pend_q[rs_a] | pend_q[rs_b];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        wb_en_d      = 4'b0000;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;

        if (w_grant_alu) begin
            last_grant_d     = GRANT_ALU;
            wb_en_d[alu_rd]  = 1'b1;
            wb_data_d        = alu_data;
            wb_rd_d          = alu_rd;
        end else if (w_grant_mem) begin
            last_grant_d     = GRANT_MEM;
            wb_en_d[mem_rd]  = 1'b1;
            wb_data_d        = mem_data;
            wb_rd_d          = mem_rd;
        end
    end

    // Clear before set, so a new issue wins over a return to the same
    // register in the same cycle.
    always_comb begin
        pend_d = pend_q;
        if (w_grant_mem) begin
            pend_d[mem_rd] = 1'b0;
        end
        if (mem_issue) begin
            pend_d[mem_issue_rd] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Reset leaves last_grant at MEM, so the ALU wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_MEM;
            pend_q       <= 4'b0000;
            wb_en_q      <= 4'b0000;
            wb_data_q    <= '0;
            wb_rd_q      <= 2'd0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            wb_en_q      <= wb_en_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_data = wb_data_q;
    assign wb_rd   = wb_rd_q;
    assign reg0_en = wb_en_q[0];
    assign reg1_en = wb_en_q[1];
    assign reg2_en = wb_en_q[2];
    assign reg3_en = wb_en_q[3];

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Self-checking bench for wb_port_arbiter. A table of directed
//             vectors is applied one per clock. Comb outputs are compared
//             mid-cycle, and registered outputs are compared just after
//             the following rising edge. Hand-written sequences cover
//             asynchronous reset in the middle of a write.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DATA_W = 8;
    localparam int NVEC   = 18;

    logic              clk;
    logic              rst;
    logic              alu_valid, alu_kill, alu_ready;
    logic [1:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [1:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_issue;
    logic [1:0]        mem_issue_rd;
    logic [1:0]        rs_a, rs_b;
    logic              hazard;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        wb_rd;
    logic              reg0_en, reg1_en, reg2_en, reg3_en;

    wb_port_arbiter #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_kill     (alu_kill),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .mem_issue    (mem_issue),
        .mem_issue_rd (mem_issue_rd),
        .rs_a         (rs_a),
        .rs_b         (rs_b),
        .hazard       (hazard),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .reg0_en      (reg0_en),
        .reg1_en      (reg1_en),
        .reg2_en      (reg2_en),
        .reg3_en      (reg3_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;   logic [1:0] ard; logic [7:0] adat; logic ak;
        logic       mv;   logic [1:0] mrd; logic [7:0] mdat;
        logic       iss;  logic [1:0] ird;
        logic [1:0] ra;   logic [1:0] rb;
        logic       ear;  logic       emr; logic       ehz;
        logic [3:0] een;  logic [7:0] ewd; logic [1:0] ewr;
    } vec_t;

    vec_t vec [NVEC];
    int   n_tests;
    int   n_fail;

    function automatic logic [3:0] en_bus();
        return {reg3_en, reg2_en, reg1_en, reg0_en};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0; alu_kill = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        mem_issue = 0; mem_issue_rd = 0; rs_a = 0; rs_b = 0;
    endtask

    initial begin
        // Fields: av ard adat ak | mv mrd mdat | iss ird | ra rb |
        //         exp alu_ready mem_ready hazard | exp en wb_data wb_rd
        vec[0]  = '{0,0,8'h00,0, 0,0,8'h00, 0,0, 0,0, 0,0,0, 4'h0,8'h00,0}; // idle
        vec[1]  = '{1,2,8'h5A,0, 0,0,8'h00, 0,0, 0,0, 1,0,0, 4'h4,8'h5A,2}; // single ALU
        vec[2]  = '{0,0,8'h00,0, 0,0,8'h00, 0,0, 0,0, 0,0,0, 4'h0,8'h5A,2}; // hold
        vec[3]  = '{1,1,8'h11,0, 1,3,8'h33, 0,0, 0,0, 0,1,0, 4'h8,8'h33,3}; // MEM's turn
        vec[4]  = '{1,1,8'h11,0, 1,3,8'h33, 0,0, 0,0, 1,0,0, 4'h2,8'h11,1}; // ALU's turn
        vec[5]  = '{1,0,8'hFF,1, 1,1,8'h77, 0,0, 0,0, 1,1,0, 4'h2,8'h77,1}; // kill + MEM
        vec[6]  = '{0,0,8'h00,0, 0,0,8'h00, 1,2, 2,0, 0,0,0, 4'h0,8'h77,1}; // issue rd2
        vec[7]  = '{1,2,8'hA2,0, 0,0,8'h00, 0,0, 2,0, 0,0,1, 4'h0,8'h77,1}; // WAW block
        vec[8]  = '{1,2,8'hA2,0, 1,2,8'hB2, 0,0, 2,0, 0,1,1, 4'h4,8'hB2,2}; // load returns
        vec[9]  = '{1,2,8'hA2,0, 0,0,8'h00, 0,0, 2,0, 1,0,0, 4'h4,8'hA2,2}; // ALU released
        vec[10] = '{0,0,8'h00,0, 0,0,8'h00, 1,3, 0,3, 0,0,0, 4'h0,8'hA2,2}; // issue rd3
        vec[11] = '{0,0,8'h00,0, 1,3,8'h3C, 1,3, 0,3, 0,1,1, 4'h8,8'h3C,3}; // set+clear rd3
        vec[12] = '{1,0,8'h0E,0, 0,0,8'h00, 0,0, 0,3, 1,0,1, 4'h1,8'h0E,0}; // pend[3] kept
        vec[13] = '{0,0,8'h00,0, 1,3,8'h4D, 0,0, 0,3, 0,1,1, 4'h8,8'h4D,3}; // rd3 returns
        vec[14] = '{0,0,8'h00,0, 0,0,8'h00, 0,0, 0,3, 0,0,0, 4'h0,8'h4D,3}; // hazard gone
        vec[15] = '{1,0,8'h01,0, 1,1,8'h02, 0,0, 0,0, 1,0,0, 4'h1,8'h01,0}; // alternate
        vec[16] = '{1,0,8'h01,0, 1,1,8'h02, 0,0, 0,0, 0,1,0, 4'h2,8'h02,1};
        vec[17] = '{1,0,8'h01,0, 1,1,8'h02, 0,0, 0,0, 1,0,0, 4'h1,8'h01,0};

        n_tests = 0;
        n_fail  = 0;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_en",     -1, {28'b0, en_bus()}, 32'h0);
        check("reset_wbdata", -1, {24'b0, wb_data},  32'h0);
        check("reset_hazard", -1, {31'b0, hazard},   32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            alu_valid = vec[i].av;  alu_rd = vec[i].ard; alu_data = vec[i].adat;
            alu_kill  = vec[i].ak;
            mem_valid = vec[i].mv;  mem_rd = vec[i].mrd; mem_data = vec[i].mdat;
            mem_issue = vec[i].iss; mem_issue_rd = vec[i].ird;
            rs_a = vec[i].ra;       rs_b = vec[i].rb;
            #1;
            check("alu_ready", i, {31'b0, alu_ready}, {31'b0, vec[i].ear});
            check("mem_ready", i, {31'b0, mem_ready}, {31'b0, vec[i].emr});
            check("hazard",    i, {31'b0, hazard},    {31'b0, vec[i].ehz});
            @(posedge clk);
            #1;
            check("reg_en",  i, {28'b0, en_bus()}, {28'b0, vec[i].een});
            check("wb_data", i, {24'b0, wb_data},  {24'b0, vec[i].ewd});
            check("wb_rd",   i, {30'b0, wb_rd},    {30'b0, vec[i].ewr});
        end

        // Asynchronous reset while reg2_en is high and pend[1] is set.
        @(negedge clk);
        drive_idle();
        alu_valid = 1; alu_rd = 2; alu_data = 8'h5A;
        mem_issue = 1; mem_issue_rd = 1; rs_a = 1;
        @(posedge clk);
        #1;
        check("midrst_pre_en",  0, {28'b0, en_bus()}, 32'h4);
        check("midrst_pre_hz",  0, {31'b0, hazard},   32'h1);
        rst = 1'b1;
        #1;
        check("midrst_en",      0, {28'b0, en_bus()}, 32'h0);
        check("midrst_hazard",  0, {31'b0, hazard},   32'h0);
        check("midrst_wbdata",  0, {24'b0, wb_data},  32'h0);

        // After release, first contention goes to the ALU, then the MEM.
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        alu_valid = 1; alu_rd = 1; alu_data = 8'h11;
        mem_valid = 1; mem_rd = 3; mem_data = 8'h33;
        #1;
        check("post_rst_alu_rdy", 0, {30'b0, alu_ready, mem_ready}, 32'h2);
        @(posedge clk);
        #1;
        check("post_rst_en1",     0, {28'b0, en_bus()}, 32'h2);
        @(negedge clk);
        #1;
        check("post_rst_mem_rdy", 0, {30'b0, alu_ready, mem_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("post_rst_en2",     0, {28'b0, en_bus()}, 32'h8);
        check("post_rst_wbdata",  0, {24'b0, wb_data},  32'h33);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("post_rst_idle",    0, {28'b0, en_bus()}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
